regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the single register-file write port (we3/wa3/wd3) between the monocycle core's
//   writeback and NPORTS input (entrada) units using a valid/ack handshake.
//   Sits between the core datapath and the regfile.
//   Core has priority. Input units are served round-robin, either in cycles with no core write
//   or by stalling the core for one cycle after MAX_WAIT cycles of starvation.
//   cpu_stall drives the PC register's enable, inverted.
// PARAMETERS
//   NPORTS    4  number of input-unit requesters (2..8)
//   WIDTH     8  data width, matches the regfile
//   AW        4  register address width (16 registers)
//   MAX_WAIT  3  consecutive denied cycles before a steal (1..15)
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-low (0 = reset), sampled on posedge clk
//   cpu_we     in   1            core writeback enable
//   cpu_wa     in   AW           core write address
//   cpu_wd     in   WIDTH        core write data
//   cpu_stall  out  1            1 = hold PC this cycle; the core instruction re-executes
//   io_req     in   NPORTS       per-port write request; held until acked
//   io_wa      in   NPORTS*AW    packed addresses; port i at [i*AW +: AW]
//   io_wd      in   NPORTS*WIDTH packed data; port i at [i*WIDTH +: WIDTH]
//   io_ack     out  NPORTS       one-hot pulse; the port's write is performed this cycle
//   we3        out  1            regfile write enable
//   wa3        out  AW           regfile write address
//   wd3        out  WIDTH        regfile write data
//   grant_io   out  1            1 = the current write belongs to an input port
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//       - state=NORMAL, rr_ptr=0, wait_cnt=0.
//       - Outputs settle to we3=0, cpu_stall=0, io_ack=0, grant_io=0 while cpu_we=0 and io_req=0.
//       - Reset mid-steal aborts the steal; no ack is issued for a write not yet performed.
//   - Grant selection is combinational from registered state:
//       - winner = first port with io_req set, searching rr_ptr, rr_ptr+1, ... mod NPORTS.
//   - FSM NORMAL:
//       - cpu_we=1 -> core owns the port. we3=1, wa3/wd3=cpu_wa/cpu_wd, cpu_stall=0.
//       - cpu_we=0 and |io_req -> winner owns the port. io_ack[winner]=1, grant_io=1.
//       - Otherwise we3=0.
//   - FSM STEAL:
//       - |io_req -> winner owns the port, cpu_stall=1, core write suppressed.
//       - io_req==0 -> behaves as NORMAL, cpu_stall=0.
//       - Always returns to NORMAL on the next edge (steal lasts 1 cycle).
//   - NORMAL->STEAL transition: on the edge where |io_req and no io grant in this cycle
//     and wait_cnt==MAX_WAIT-1.
//   - wait_cnt:
//       - +1 on each cycle with |io_req and no io grant, saturating at MAX_WAIT.
//       - Cleared on any io grant or when io_req==0.
//   - rr_ptr: after granting port i, becomes (i+1) mod NPORTS. Unchanged otherwise.
//   - io write to wa=0:
//       - Acked and rr_ptr advances, but we3=0 (R0 is constant zero).
//       - Core writes to R0 pass through unchanged.
//   - At most one io_ack bit per cycle. An ack is never issued in a cycle with io_req[i]=0.
//   - A requester may change io_wa/io_wd only after its ack.
//   - Latency:
//       - Core write: 0 cycles.
//       - Io write with core idle: 0 cycles.
//       - Worst case for port i under a continuous core write stream: NPORTS*(MAX_WAIT+1) cycles.
// STRUCTURE
//   - Shared include arb_defs.vh holds:
//       - state encoding: NORMAL=1'b0, STEAL=1'b1
//       - regfile geometry constants (AW=4, WIDTH=8)
//   - Sub-module rr_pick #(N): combinational rotate-priority encoder.
//       - Inputs: req[N-1:0], ptr.
//       - Outputs: valid, idx.
//   - Top level holds the FSM, wait_cnt, rr_ptr, and the output muxes.
// TESTING
//   1. reset=0 for 2 cycles with io_req=4'b1111
//      -> we3=0, io_ack=0, cpu_stall=0. First cycle after release (cpu_we=0): io_ack=0001.
//   2. cpu_we=0; io_req=0101 with wa0=3/wd0=8'hA5, wa2=7/wd2=8'h3C
//      -> cycle 1: ack0001, reg3=A5. Drop req0; cycle 2: ack0100, reg7=3C.
//   3. cpu_we=1 continuously; io_req=0010 (wa=5, wd=8'h11)
//      -> 3 cycles of core writes, then 1 cycle with cpu_stall=1, ack0010, reg5=11.
//      -> Next cycle: cpu_stall=0.
//   4. io_req=0001 with wa=0, wd=8'hFF, cpu_we=0
//      -> ack0001, we3=0; reg0 still reads 0.
//   5. Reach STEAL (as test 3), then drop io_req in the STEAL cycle
//      -> cpu_stall=0, core write performed, state back to NORMAL.
//   6. Reset asserted in the STEAL cycle
//      -> next cycle state=NORMAL, wait_cnt=0, no ack issued, core write proceeds.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// ============================================================================
// Module : regfile_wr_arbiter_pkg
// Brief  : Shared state encoding and regfile geometry for the write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STEAL  = 1'b1
  } arb_state_t;

  localparam int c_reg_aw    = 4;
  localparam int c_reg_width = 8;
  localparam int c_cnt_w     = 4;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority encoder; first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  // Scan from farthest to nearest so the port closest to ptr is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module : regfile_wr_arbiter
// Brief  : Shares the regfile write port between core writeback and NPORTS
//          input units; core first, input units round-robin with bounded stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NPORTS   = 4,
  parameter int WIDTH    = c_reg_width,
  parameter int AW       = c_reg_aw,
  parameter int MAX_WAIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_we,
  input  logic [AW-1:0]           cpu_wa,
  input  logic [WIDTH-1:0]        cpu_wd,
  output logic                    cpu_stall,
  input  logic [NPORTS-1:0]       io_req,
  input  logic [NPORTS*AW-1:0]    io_wa,
  input  logic [NPORTS*WIDTH-1:0] io_wd,
  output logic [NPORTS-1:0]       io_ack,
  output logic                    we3,
  output logic [AW-1:0]           wa3,
  output logic [WIDTH-1:0]        wd3,
  output logic                    grant_io
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [PW-1:0]      r_rr_ptr;
  logic [c_cnt_w-1:0] r_wait_cnt;

  logic               w_any_req;
  logic               w_pick_valid;
  logic [PW-1:0]      w_pick_idx;
  logic               w_io_grant;
  logic [AW-1:0]      w_io_wa;
  logic [WIDTH-1:0]   w_io_wd;
  logic [PW-1:0]      w_ptr_nxt;

  assign w_any_req = |io_req;

  rr_pick #(
    .N  (NPORTS),
    .PW (PW)
  ) u_rr_pick (
    .req   (io_req),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_io_wa   = io_wa[w_pick_idx*AW +: AW];
  assign w_io_wd   = io_wd[w_pick_idx*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_pick_idx == PW'(NPORTS - 1)) ? '0 : w_pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An io grant is withheld while reset is low so an aborted steal never acks.
  always_comb begin
    w_state_nxt = NORMAL;
    w_io_grant  = 1'b0;
    cpu_stall   = 1'b0;
    case (r_state)
      NORMAL: begin
        w_io_grant = reset && !cpu_we && w_pick_valid;
        if (w_any_req && !w_io_grant && (r_wait_cnt == c_cnt_w'(MAX_WAIT - 1))) begin
          w_state_nxt = STEAL;
        end
      end
      STEAL: begin
        w_io_grant = reset && w_pick_valid;
        cpu_stall  = w_io_grant;
      end
      default: w_state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    we3      = 1'b0;
    wa3      = cpu_wa;
    wd3      = cpu_wd;
    io_ack   = '0;
    grant_io = w_io_grant;
    if (w_io_grant) begin
      // R0 is hard-wired to zero: the io write is acked but not committed.
      we3                = (w_io_wa != '0);
      wa3                = w_io_wa;
      wd3                = w_io_wd;
      io_ack[w_pick_idx] = 1'b1;
    end else if (cpu_we) begin
      we3 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_io_grant) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_io_grant || !w_any_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt < c_cnt_w'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module : tb_regfile_wr_arbiter
// Brief  : Directed vector bench for regfile_wr_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

  localparam logic [15:0] IWA  = 16'h9753;
  localparam logic [31:0] IWD  = 32'hC33C11A5;
  localparam logic [15:0] IWA0 = 16'h9750;
  localparam logic [31:0] IWD0 = 32'hC33C11FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [3:0]  cpu_wa;
  logic [7:0]  cpu_wd;
  logic        cpu_stall;
  logic [3:0]  io_req;
  logic [15:0] io_wa;
  logic [31:0] io_wd;
  logic [3:0]  io_ack;
  logic        we3;
  logic [3:0]  wa3;
  logic [7:0]  wd3;
  logic        grant_io;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NPORTS   (4),
    .WIDTH    (8),
    .AW       (4),
    .MAX_WAIT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_wa    (cpu_wa),
    .cpu_wd    (cpu_wd),
    .cpu_stall (cpu_stall),
    .io_req    (io_req),
    .io_wa     (io_wa),
    .io_wd     (io_wd),
    .io_ack    (io_ack),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .grant_io  (grant_io)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [3:0]  req;
    logic [15:0] iwa;
    logic [31:0] iwd;
    logic        e_we3;
    logic [3:0]  e_wa3;
    logic [7:0]  e_wd3;
    logic        e_stall;
    logic [3:0]  e_ack;
    logic        e_gio;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic we, input logic [3:0] wa,
                             input logic [7:0] wd, input logic [3:0] req,
                             input logic [15:0] iwa, input logic [31:0] iwd,
                             input logic ewe, input logic [3:0] ewa, input logic [7:0] ewd,
                             input logic est, input logic [3:0] eack, input logic egio);
    vec_t t;
    t.rst_n = r;   t.we = we;     t.wa = wa;       t.wd = wd;     t.req = req;
    t.iwa = iwa;   t.iwd = iwd;   t.e_we3 = ewe;   t.e_wa3 = ewa; t.e_wd3 = ewd;
    t.e_stall = est; t.e_ack = eack; t.e_gio = egio;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    cpu_we = 1'b0;
    cpu_wa = '0;
    cpu_wd = '0;
    io_req = '0;
    io_wa  = IWA;
    io_wd  = IWD;

    // reset with all ports requesting, then first grant goes to port 0
    vecs.push_back(v(0,0,4'h0,8'h00,4'hF,IWA,IWD, 0,4'h0,8'h00,0,4'h0,0));
    vecs.push_back(v(0,0,4'h0,8'h00,4'hF,IWA,IWD, 0,4'h0,8'h00,0,4'h0,0));
    vecs.push_back(v(1,0,4'h0,8'h00,4'hF,IWA,IWD, 1,4'h3,8'hA5,0,4'h1,1));
    // re-reset, then two ports served in turn
    vecs.push_back(v(0,0,4'h0,8'h00,4'h0,IWA,IWD, 0,4'h0,8'h00,0,4'h0,0));
    vecs.push_back(v(1,0,4'h0,8'h00,4'h5,IWA,IWD, 1,4'h3,8'hA5,0,4'h1,1));
    vecs.push_back(v(1,0,4'h0,8'h00,4'h4,IWA,IWD, 1,4'h7,8'h3C,0,4'h4,1));
    // starvation under a core stream -> one steal cycle
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h5,8'h11,1,4'h2,1));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h0,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    // io write to R0 acked but suppressed; core write to R0 passes
    vecs.push_back(v(1,0,4'h0,8'h00,4'h1,IWA0,IWD0, 0,4'h0,8'h00,0,4'h1,1));
    vecs.push_back(v(1,1,4'h0,8'h77,4'h0,IWA,IWD, 1,4'h0,8'h77,0,4'h0,0));
    // reach STEAL, drop request in the steal cycle, then confirm back in NORMAL
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h0,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    // reset lands in the STEAL cycle: no ack, core write proceeds, wait restarts
    vecs.push_back(v(0,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h2,8'h55,0,4'h0,0));
    vecs.push_back(v(1,1,4'h2,8'h55,4'h2,IWA,IWD, 1,4'h5,8'h11,1,4'h2,1));
    // round-robin rotation with all ports requesting, pointer at 2
    vecs.push_back(v(1,0,4'h0,8'h00,4'hF,IWA,IWD, 1,4'h7,8'h3C,0,4'h4,1));
    vecs.push_back(v(1,0,4'h0,8'h00,4'hF,IWA,IWD, 1,4'h9,8'hC3,0,4'h8,1));
    vecs.push_back(v(1,0,4'h0,8'h00,4'hF,IWA,IWD, 1,4'h3,8'hA5,0,4'h1,1));
    vecs.push_back(v(1,0,4'h0,8'h00,4'hF,IWA,IWD, 1,4'h5,8'h11,0,4'h2,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset  = vecs[i].rst_n;
      cpu_we = vecs[i].we;
      cpu_wa = vecs[i].wa;
      cpu_wd = vecs[i].wd;
      io_req = vecs[i].req;
      io_wa  = vecs[i].iwa;
      io_wd  = vecs[i].iwd;
      #4;
      chk("we3", i, int'(we3), int'(vecs[i].e_we3));
      if (vecs[i].e_we3) begin
        chk("wa3", i, int'(wa3), int'(vecs[i].e_wa3));
        chk("wd3", i, int'(wd3), int'(vecs[i].e_wd3));
      end
      chk("cpu_stall", i, int'(cpu_stall), int'(vecs[i].e_stall));
      chk("io_ack", i, int'(io_ack), int'(vecs[i].e_ack));
      chk("grant_io", i, int'(grant_io), int'(vecs[i].e_gio));
    end

    // every port is served within NPORTS*(MAX_WAIT+1) cycles under a constant core stream
    begin
      logic [3:0] pending;
      int         cyc;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      io_req = '0;
      io_wa  = IWA;
      io_wd  = IWD;
      pending = 4'hF;
      cyc     = 0;
      while (pending != 4'h0 && cyc < 16) begin
        @(posedge clk);
        #1;
        reset  = 1'b1;
        cpu_we = 1'b1;
        cpu_wa = 4'h2;
        cpu_wd = 8'h55;
        io_req = pending;
        #4;
        cyc++;
        if (io_ack != 4'h0) begin
          chk("ack_onehot", 100 + cyc, int'($onehot(io_ack)), 1);
          chk("ack_without_req", 100 + cyc, int'(io_ack & ~pending), 0);
          chk("steal_stall", 100 + cyc, int'(cpu_stall), 1);
          chk("steal_period", 100 + cyc, cyc % 4, 0);
          pending = pending & ~io_ack;
        end
      end
      chk("latency_bound_pending", 200, int'(pending), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
